// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSw,
        StRmwRd,
        StRmwWr,
        StFault,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extract/extend a load lane from a word, and merge
// a sub-word store into a word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[{addr_lo, 3'b000} +: 8];
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];

        case (op)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = word;
        endcase

        store_data = word;
        case (op)
            F3_B: store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (addr_lo[1]) store_data[31:16] = wdata;
                else            store_data[15:0]  = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Bridges single load/store requests onto a word-only memory port; sub-word stores
// are done as read-modify-write, and faulting requests never touch memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_IDX_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_e  state_q, state_d;
    logic        store_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        req_fault;
    logic        op_fault;
    logic [31:0] load_data;
    logic [31:0] store_data;

    // Misalignment and op legality depend on direction: BU/HU exist for loads only.
    always_comb begin
        case (req_op)
            F3_B:    op_fault = 1'b0;
            F3_H:    op_fault = req_addr[0];
            F3_W:    op_fault = |req_addr[1:0];
            F3_BU:   op_fault = req_store;
            F3_HU:   op_fault = req_store | req_addr[0];
            default: op_fault = 1'b1;
        endcase
        req_fault = op_fault || ((req_addr >> (MEM_IDX_W + 2)) != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_fault)         state_d = StFault;
                    else if (!req_store)   state_d = StLoad;
                    else if (req_op == F3_W) state_d = StSw;
                    else                   state_d = StRmwRd;
                end
            end
            StLoad:           state_d = StResp;
            StSw:             state_d = StResp;
            StRmwRd:          state_d = StRmwWr;
            StRmwWr:          state_d = StResp;
            StFault, StResp:  state_d = StIdle;
            default:          state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == StIdle);
        mem_read       = (state_q == StLoad) || (state_q == StRmwRd);
        mem_write      = (state_q == StSw) || (state_q == StRmwWr);
        mem_address    = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_write_data = 32'h0;
        if (state_q == StSw)    mem_write_data = wdata_q;
        if (state_q == StRmwWr) mem_write_data = merge_q;
        resp_valid     = (state_q == StFault) || (state_q == StResp);
        resp_fault     = (state_q == StFault);
        resp_rdata     = rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_q <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            if (req_valid && req_ready) begin
                store_q <= req_store;
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == StRmwRd) merge_q <= store_data;
            // Only the LOAD->RESP edge loads data, so rdata is zero outside the RESP pulse.
            rdata_q <= (state_q == StLoad) ? load_data : 32'h0;
        end
    end

    lsu_lane_align u_lane_align (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .word       (mem_read_data),
        .wdata      (wdata_q[15:0]),
        .load_data  (load_data),
        .store_data (store_data)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: load_store_unit paired with a word memory, directed and random
// requests compared against an arithmetic reference model.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem   [MEM_WORDS] = '{4: 32'h8899AABB, default: 32'h0};
    logic [31:0] model [MEM_WORDS] = '{4: 32'h8899AABB, default: 32'h0};

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_IDX_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_fault(input logic st, input logic [2:0] op, input logic [31:0] addr);
        int unsigned sz;
        case (op)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        if (sz == 0) return 1'b1;
        if (st && op > 3'd2) return 1'b1;
        if (addr >= 4 * MEM_WORDS) return 1'b1;
        return (addr % sz) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] word, v;
        int unsigned sh;
        word = model[addr[9:2]];
        sh   = 8 * (addr % 4);
        if (op == 3'd2) return word;
        if (op == 3'd0 || op == 3'd4) begin
            v = (word >> sh) & 32'hFF;
            if (op == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
        end else begin
            v = (word >> sh) & 32'hFFFF;
            if (op == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] wd, input logic [31:0] old);
        logic [31:0] mask;
        int unsigned sh;
        sh = 8 * (addr % 4);
        if (op == 3'd2) return wd;
        mask = ((op == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // Entered and left on a negedge with the unit idle.
    task automatic run_req(input logic st, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input bit hold);
        bit          flt, got;
        logic [31:0] exp_rd, exp_word;
        int          exp_lat, exp_rds, exp_wrs, rds, wrs, lat, waitn;
        flt      = ref_fault(st, op, addr);
        exp_rd   = 32'h0;
        exp_word = 32'h0;
        exp_rds  = 0;
        exp_wrs  = 0;
        if (flt) begin
            exp_lat = 1;
        end else if (!st) begin
            exp_lat = 2;
            exp_rd  = ref_load(op, addr);
            exp_rds = 1;
        end else begin
            exp_word = ref_store(op, addr, wd, model[addr[9:2]]);
            exp_wrs  = 1;
            exp_rds  = (op == 3'd2) ? 0 : 1;
            exp_lat  = 2 + exp_rds;
        end

        req_store = st;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        waitn = 0;
        while (!req_ready && waitn < 10) begin
            @(negedge clk);
            waitn++;
        end
        check("accept_ready", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;

        rds = 0;
        wrs = 0;
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_read)  rds++;
            if (mem_write) wrs++;
            check("rd_wr_excl", {31'h0, mem_read & mem_write}, 32'd0);
            if (mem_read || mem_write) check("mem_addr", mem_address, {addr[31:2], 2'b00});
            if (mem_write) check("mem_wdata", mem_write_data, exp_word);
            if (resp_valid) begin
                got = 1'b1;
                lat = c;
                check("resp_fault", {31'h0, resp_fault}, {31'h0, flt});
                check("resp_rdata", resp_rdata, exp_rd);
            end else begin
                check("busy_ready", {31'h0, req_ready}, 32'd0);
            end
        end
        check("resp_seen", {31'h0, got}, 32'd1);
        check("latency", lat, exp_lat);
        check("mem_reads", rds, exp_rds);
        check("mem_writes", wrs, exp_wrs);
        if (!flt && st) model[addr[9:2]] = exp_word;

        @(negedge clk);
        check("idle_ready", {31'h0, req_ready}, 32'd1);
        check("idle_resp", {30'h0, resp_valid, resp_fault}, 32'd0);
        check("idle_rdata", resp_rdata, 32'h0);
        check("idle_mem", {30'h0, mem_read, mem_write}, 32'd0);
        check("idle_addr", mem_address | mem_write_data, 32'h0);
        if (!flt) check("mem_word", mem[addr[9:2]], model[addr[9:2]]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_resp", {30'h0, resp_valid, resp_fault}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_mem", {30'h0, mem_read, mem_write}, 32'd0);
        check("rst_addr", mem_address, 32'h0);
        check("rst_wdata", mem_write_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'd1);

        // LB / LBU from preloaded word
        run_req(1'b0, 3'd0, 32'h12, 32'h0, 1'b0);
        run_req(1'b0, 3'd4, 32'h12, 32'h0, 1'b0);
        // SB read-modify-write
        run_req(1'b1, 3'd0, 32'h11, 32'h55, 1'b0);
        check("sb_merged", mem[4], 32'h889955BB);
        // Misaligned LH, out-of-range SW
        run_req(1'b0, 3'd1, 32'h13, 32'h0, 1'b0);
        run_req(1'b1, 3'd2, 32'h400, 32'h12345678, 1'b0);

        // Reset during RMW_WR
        req_store = 1'b1;
        req_op    = 3'd0;
        req_addr  = 32'h11;
        req_wdata = 32'h77;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_rd_phase", {31'h0, mem_read}, 32'd1);
        @(negedge clk);
        check("rmw_wr_phase", {31'h0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_write", {30'h0, mem_write, mem_read}, 32'd0);
        check("rst_mid_resp", {31'h0, resp_valid}, 32'd0);
        @(negedge clk);
        check("rst_hold_resp", {31'h0, resp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rel_ready", {31'h0, req_ready}, 32'd1);
        check("rst_rel_resp", {31'h0, resp_valid}, 32'd0);
        check("rst_word_kept", mem[4], model[4]);

        // Back-to-back SW then LW with req_valid held
        run_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
        run_req(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
        check("b2b_word", mem[4], 32'hDEADBEEF);

        // Signed/unsigned halfword lanes
        run_req(1'b1, 3'd1, 32'h22, 32'h0000C3A5, 1'b0);
        run_req(1'b0, 3'd1, 32'h22, 32'h0, 1'b0);
        run_req(1'b0, 3'd5, 32'h22, 32'h0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                    1'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;
        @(negedge clk);

        mism = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== model[i]) mism++;
        check("mem_final", mism, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
